// File: rtl/block_sync_rx_pkg.sv
// Shared PCS definitions for the 64b/66b block synchroniser.
package block_sync_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SLIP   = 2'd2
    } bs_state_e;

    localparam logic [1:0] SH_VALID_01 = 2'b01;
    localparam logic [1:0] SH_VALID_10 = 2'b10;

    localparam int unsigned SH_CNT_MAX_DEF   = 64;
    localparam int unsigned SH_INVLD_MAX_DEF = 16;
    localparam int unsigned SLIP_WAIT_DEF    = 4;

    // A sync header is legal only when its two bits differ.
    function automatic logic sh_valid(input logic [1:0] head);
        return (head == SH_VALID_01) || (head == SH_VALID_10);
    endfunction

endpackage

// File: rtl/block_sync_rx_sh_cnt_win.sv
// Sync-header test window: blocks tested and invalid headers seen in the
// current window, with flags raised on the block that reaches each limit.
module sh_cnt_win
    import block_sync_rx_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX   = SH_CNT_MAX_DEF,
    parameter int unsigned SH_INVLD_MAX = SH_INVLD_MAX_DEF
) (
    input  logic clk,
    input  logic nreset,
    input  logic clr_i,
    input  logic inc_i,
    input  logic invld_i,
    output logic win_end_o,
    output logic invld_lim_o
);

    localparam logic [6:0] CNT_LAST   = 7'(SH_CNT_MAX);
    localparam logic [4:0] INVLD_LAST = 5'(SH_INVLD_MAX);

    logic [6:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
    logic [4:0] sh_invld_cnt_q, sh_invld_cnt_d, sh_invld_cnt_inc;

    // Next counter values and limit flags for the block presented this cycle.
    always_comb begin
        sh_cnt_inc       = sh_cnt_q + 7'd1;
        sh_invld_cnt_inc = sh_invld_cnt_q + {4'd0, invld_i};
        win_end_o        = inc_i && (sh_cnt_inc == CNT_LAST);
        invld_lim_o      = inc_i && invld_i && (sh_invld_cnt_inc == INVLD_LAST);
        sh_cnt_d         = sh_cnt_q;
        sh_invld_cnt_d   = sh_invld_cnt_q;
        if (clr_i || win_end_o || invld_lim_o) begin
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
        end else if (inc_i) begin
            sh_cnt_d       = sh_cnt_inc;
            sh_invld_cnt_d = sh_invld_cnt_inc;
        end
    end

    // Window counter registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sh_cnt_q       <= '0;
            sh_invld_cnt_q <= '0;
        end else begin
            sh_cnt_q       <= sh_cnt_d;
            sh_invld_cnt_q <= sh_invld_cnt_d;
        end
    end

endmodule

// File: rtl/block_sync_rx.sv
// 64b/66b block lock state machine with a registered pass-through datapath
// towards the descrambler.
module block_sync_rx
    import block_sync_rx_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX   = SH_CNT_MAX_DEF,
    parameter int unsigned SH_INVLD_MAX = SH_INVLD_MAX_DEF,
    parameter int unsigned SLIP_WAIT    = SLIP_WAIT_DEF
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        valid_i,
    input  logic [1:0]  head_i,
    input  logic [63:0] data_i,
    output logic        slip_o,
    output logic        lock_o,
    output logic        valid_o,
    output logic [1:0]  head_o,
    output logic [63:0] data_o
);

    localparam int unsigned SLIP_W    = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

    bs_state_e         state_q;
    logic [SLIP_W-1:0] slip_cnt_q;
    logic              slip_q, lock_q, valid_q;
    logic [1:0]        head_q;
    logic [63:0]       data_q;

    logic hdr_ok, cnt_clr, cnt_inc, win_end, invld_lim;

    // Window counter control: HUNT only counts good headers (a bad one slips),
    // LOCKED counts every block, SLIP keeps the window empty.
    always_comb begin
        hdr_ok  = sh_valid(head_i);
        cnt_inc = valid_i && ((state_q == ST_LOCKED) || ((state_q == ST_HUNT) && hdr_ok));
        cnt_clr = (state_q == ST_SLIP) || (valid_i && (state_q == ST_HUNT) && !hdr_ok);
    end

    sh_cnt_win #(
        .SH_CNT_MAX  (SH_CNT_MAX),
        .SH_INVLD_MAX(SH_INVLD_MAX)
    ) u_sh_cnt_win (
        .clk        (clk),
        .nreset     (nreset),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .invld_i    (!hdr_ok),
        .win_end_o  (win_end),
        .invld_lim_o(invld_lim)
    );

    // Lock FSM plus registered outputs; slip_q is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= ST_HUNT;
            slip_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            data_q     <= '0;
        end else begin
            slip_q  <= 1'b0;
            valid_q <= valid_i && lock_q;
            if (valid_i) begin
                head_q <= head_i;
                data_q <= data_i;
                case (state_q)
                    ST_HUNT: begin
                        if (!hdr_ok) begin
                            state_q    <= ST_SLIP;
                            slip_q     <= 1'b1;
                            slip_cnt_q <= '0;
                        end else if (win_end) begin
                            state_q <= ST_LOCKED;
                            lock_q  <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (invld_lim) begin
                            state_q    <= ST_SLIP;
                            slip_q     <= 1'b1;
                            lock_q     <= 1'b0;
                            slip_cnt_q <= '0;
                        end
                    end
                    ST_SLIP: begin
                        if (slip_cnt_q == SLIP_LAST) begin
                            state_q    <= ST_HUNT;
                            slip_cnt_q <= '0;
                        end else begin
                            slip_cnt_q <= slip_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    assign slip_o  = slip_q;
    assign lock_o  = lock_q;
    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_block_sync_rx.sv
// Scoreboard bench for block_sync_rx: a behavioural model pushes the expected
// outputs for every driven cycle, which are popped and compared after the edge.
module tb_block_sync_rx;

    localparam int CNT_MAX   = 64;
    localparam int INVLD_MAX = 16;
    localparam int SWAIT     = 4;

    localparam int M_HUNT = 0;
    localparam int M_LOCK = 1;
    localparam int M_SLIP = 2;

    typedef struct packed {
        logic        slip;
        logic        lock;
        logic        vo;
        logic [1:0]  head;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        valid_i;
    logic [1:0]  head_i;
    logic [63:0] data_i;
    logic        slip_o, lock_o, valid_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb[$];

    int          m_state, m_cnt, m_inv, m_scnt;
    logic        m_lock;
    logic [1:0]  m_head;
    logic [63:0] m_data;

    always #5 clk = ~clk;

    block_sync_rx #(
        .SH_CNT_MAX  (CNT_MAX),
        .SH_INVLD_MAX(INVLD_MAX),
        .SLIP_WAIT   (SWAIT)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .valid_i(valid_i),
        .head_i (head_i),
        .data_i (data_i),
        .slip_o (slip_o),
        .lock_o (lock_o),
        .valid_o(valid_o),
        .head_o (head_o),
        .data_o (data_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model(input logic rst_n, input logic v, input logic [1:0] h,
                         input logic [63:0] d, output exp_t e);
        logic good;
        good = (h == 2'b01) || (h == 2'b10);
        if (!rst_n) begin
            m_state = M_HUNT; m_cnt = 0; m_inv = 0; m_scnt = 0;
            m_lock = 1'b0; m_head = 2'b00; m_data = '0;
            e = '0;
        end else begin
            e.slip = 1'b0;
            e.vo   = v && m_lock;
            if (v) begin
                m_head = h;
                m_data = d;
                case (m_state)
                    M_HUNT: begin
                        if (!good) begin
                            m_state = M_SLIP; e.slip = 1'b1;
                            m_cnt = 0; m_inv = 0; m_scnt = 0;
                        end else begin
                            m_cnt++;
                            if (m_cnt == CNT_MAX) begin
                                m_state = M_LOCK; m_lock = 1'b1; m_cnt = 0;
                            end
                        end
                    end
                    M_LOCK: begin
                        m_cnt++;
                        if (!good) m_inv++;
                        if (m_inv == INVLD_MAX) begin
                            m_state = M_SLIP; e.slip = 1'b1; m_lock = 1'b0;
                            m_cnt = 0; m_inv = 0; m_scnt = 0;
                        end else if (m_cnt == CNT_MAX) begin
                            m_cnt = 0; m_inv = 0;
                        end
                    end
                    default: begin
                        m_scnt++;
                        if (m_scnt == SWAIT) begin
                            m_state = M_HUNT; m_scnt = 0;
                        end
                    end
                endcase
            end
            e.lock = m_lock;
            e.head = m_head;
            e.data = m_data;
        end
    endtask

    task automatic step(input logic rst_n, input logic v, input logic [1:0] h, input logic [63:0] d);
        exp_t e, got;
        nreset  = rst_n;
        valid_i = v;
        head_i  = h;
        data_i  = d;
        model(rst_n, v, h, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            check("slip_o",  {63'd0, slip_o},  {63'd0, got.slip});
            check("lock_o",  {63'd0, lock_o},  {63'd0, got.lock});
            check("valid_o", {63'd0, valid_o}, {63'd0, got.vo});
            check("head_o",  {62'd0, head_o},  {62'd0, got.head});
            check("data_o",  data_o,           got.data);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic blk(input logic [1:0] h);
        step(1'b1, 1'b1, h, rnd64());
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 2'b11, rnd64());
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 2'b11, rnd64());
    endtask

    task automatic acquire();
        for (int i = 0; i < CNT_MAX; i++) blk(2'b01);
    endtask

    initial begin
        nreset = 1'b0; valid_i = 1'b0; head_i = 2'b00; data_i = '0;

        // reset state
        do_reset();
        check("rst_lock", {63'd0, lock_o}, 64'd0);

        // lock on 64 good headers, valid_o follows afterwards
        for (int i = 0; i < CNT_MAX - 1; i++) blk(2'b01);
        check("pre_lock", {63'd0, lock_o}, 64'd0);
        blk(2'b01);
        check("lock_rise", {63'd0, lock_o}, 64'd1);
        blk(2'b10);
        check("vo_locked", {63'd0, valid_o}, 64'd1);
        idle();

        // hunt slip, settle blocks ignored, window restarts from zero
        do_reset();
        for (int i = 0; i < 10; i++) blk(2'b10);
        blk(2'b11);
        check("hunt_slip", {63'd0, slip_o}, 64'd1);
        for (int i = 0; i < SWAIT; i++) begin
            blk(2'b00);
            check("no_reslip", {63'd0, slip_o}, 64'd0);
        end
        for (int i = 0; i < CNT_MAX - 1; i++) blk(2'b10);
        check("restart_nolock", {63'd0, lock_o}, 64'd0);
        blk(2'b10);
        check("restart_lock", {63'd0, lock_o}, 64'd1);

        // 15 invalid headers keep lock, 16 in the next window drop it
        for (int i = 0; i < CNT_MAX; i++) blk(i < 15 ? 2'b00 : 2'b01);
        check("lock_held", {63'd0, lock_o}, 64'd1);
        for (int i = 0; i < 16; i++) blk(i[0] ? 2'b11 : 2'b00);
        check("lock_lost", {63'd0, lock_o}, 64'd0);
        check("lock_slip", {63'd0, slip_o}, 64'd1);
        for (int i = 0; i < 8; i++) blk(2'b01);

        // 16th invalid header on the window's last block
        do_reset();
        acquire();
        for (int i = 0; i < CNT_MAX; i++) blk((i < 15 || i == CNT_MAX - 1) ? 2'b11 : 2'b10);
        check("edge_slip", {63'd0, slip_o}, 64'd1);
        check("edge_lock", {63'd0, lock_o}, 64'd0);
        for (int i = 0; i < 6; i++) blk(2'b01);

        // lock acquisition with valid_i toggling
        do_reset();
        for (int i = 0; i < CNT_MAX; i++) begin
            blk(2'b01);
            idle();
        end
        check("toggle_lock", {63'd0, lock_o}, 64'd1);

        // reset on the slip decision cycle and while locked
        for (int i = 0; i < 3; i++) blk(2'b10);
        do_reset();
        for (int i = 0; i < 5; i++) blk(2'b01);
        step(1'b0, 1'b1, 2'b11, rnd64());
        check("rst_noslip", {63'd0, slip_o}, 64'd0);
        blk(2'b01);
        check("rst_after", {63'd0, slip_o}, 64'd0);

        // randomised traffic from lock
        acquire();
        for (int i = 0; i < 600; i++) begin
            logic [1:0] h;
            h = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11)
                                             : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
            step(($urandom_range(0, 249) != 0), ($urandom_range(0, 3) != 0), h, rnd64());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/block_sync_rx.md
BLOCK_SYNC_RX -- requirements
Module: block_sync_rx

Interface
REQ-001 Parameter SH_CNT_MAX, default 64, blocks per sync-header test window.
REQ-002 Parameter SH_INVLD_MAX, default 16, invalid headers per window that force loss of lock.
REQ-003 Parameter SLIP_WAIT, default 4, valid blocks ignored after a slip while the gearbox realigns.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 nreset  input  1  reset, synchronous, active-low.
REQ-006 valid_i  input  1  a 66-bit block is present on head_i/data_i this cycle.
REQ-007 head_i  input  2  sync header, bit 0 first on the wire.
REQ-008 data_i  input  64  scrambled payload, to the descrambler.
REQ-009 slip_o  output  1  one-cycle request to the upstream gearbox to shift alignment by one bit.
REQ-010 lock_o  output  1  block lock achieved.
REQ-011 valid_o  output  1  registered block valid, gated by lock.
REQ-012 head_o  output  2  registered head_i.
REQ-013 data_o  output  64  registered data_i; feeds the descrambler scram_i with LEN=64.

Function
REQ-014 A header is valid iff head_i is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-015 States: HUNT, LOCKED, SLIP; the FSM advances only on cycles with valid_i=1, except for the SLIP entry pulse.
REQ-016 Counters: sh_cnt counts blocks tested in the window (7 bits, 0..SH_CNT_MAX); sh_invld_cnt counts invalid headers in the window (5 bits, 0..SH_INVLD_MAX); slip_cnt counts settle blocks (0..SLIP_WAIT).
REQ-017 HUNT, valid header: sh_cnt increments; when the increment makes sh_cnt reach SH_CNT_MAX, go to LOCKED, set lock_o=1 the next cycle, and clear both counters.
REQ-018 HUNT, invalid header: go to SLIP immediately, whatever the value of sh_cnt.
REQ-019 LOCKED, each valid block: sh_cnt increments, and sh_invld_cnt increments on an invalid header.
REQ-020 LOCKED: if sh_invld_cnt reaches SH_INVLD_MAX, go to SLIP and clear lock_o; this takes priority over window end on the same block.
REQ-021 LOCKED: when sh_cnt reaches SH_CNT_MAX with sh_invld_cnt below SH_INVLD_MAX, clear both counters and stay LOCKED.
REQ-022 SLIP entry: slip_o=1 for exactly the cycle after the decision, lock_o=0, all counters cleared.
REQ-023 SLIP: count SLIP_WAIT valid blocks, ignoring their headers, then go to HUNT; slip_o is not re-asserted during the wait.
REQ-024 The datapath has 1-cycle latency: data_o/head_o load on valid_i=1 and hold otherwise; valid_o = valid_i AND lock_o as sampled in that cycle.
REQ-025 valid_i=0 cycles leave all state and counters unchanged.

Reset
REQ-026 While nreset=0 at a clock edge: state=HUNT; counters=0; slip_o=0, lock_o=0, valid_o=0, head_o=2'b00, data_o=0.
REQ-027 Reset asserted mid-operation, including in SLIP or LOCKED, overrides all transitions in that cycle, and no slip_o pulse is emitted.

Structure
REQ-028 The shared PCS package holds the state enum, the SH_VALID_01/SH_VALID_10 constants and the default window constants.
REQ-029 A sub-module sh_cnt_win holds the window counters (sh_cnt, sh_invld_cnt, window-end and invalid-limit flags); the FSM and datapath stay in block_sync_rx.

Verification
REQ-030 64 consecutive blocks with head=01 after reset -> lock_o rises on the cycle after the 64th; valid_o follows valid_i from the next block.
REQ-031 HUNT with 10 valid blocks followed by one head=11 -> slip_o pulses once; then 4 blocks are ignored, HUNT resumes, and sh_cnt restarts at 0.
REQ-032 Locked, 15 invalid headers in one window -> lock held, counters clear at window end; 16 invalid in the next window -> lock_o=0 and slip_o pulses.
REQ-033 Locked, with the 16th invalid header on the 64th block -> SLIP is taken, not a window reset.
REQ-034 valid_i toggling 1/0 during lock acquisition -> lock after 64 valid-only blocks; data_o holds during valid_i=0 cycles.
REQ-035 nreset asserted on the SLIP entry cycle -> no slip_o pulse; all outputs are 0 the next cycle.
